// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared definitions for the core-side memory responder.
//   MEM_SZ_*          : store/load size codes carried on mem_wbit_en
//   MEM_BASE_DEFAULT  : default first byte address of the RAM window
//   lane_ok()         : size/lane alignment legality check
package ysyx_23060180_mem_pkg;

  localparam logic [3:0] MEM_SZ_B = 4'd1;
  localparam logic [3:0] MEM_SZ_H = 4'd2;
  localparam logic [3:0] MEM_SZ_W = 4'd4;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;

  // Unknown size codes are never legal, so they also reject the access.
  function automatic logic lane_ok(input logic [3:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      MEM_SZ_B: ok = 1'b1;
      MEM_SZ_H: ok = ~lane[0];
      MEM_SZ_W: ok = (lane == 2'd0);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060180_mem_align.sv
// Combinational byte-lane alignment for the memory responder.
//   Store path: wdata (right-justified), size, lane -> wstrb (byte strobe), wword (shifted data)
//   Load path : rword (raw RAM word), rlane        -> rdata (right-justified, zero-filled)
module ysyx_23060180_mem_align
  import ysyx_23060180_mem_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [3:0]  size,
  input  logic [1:0]  lane,
  output logic [3:0]  wstrb,
  output logic [31:0] wword,
  input  logic [31:0] rword,
  input  logic [1:0]  rlane,
  output logic [31:0] rdata
);

  always_comb begin
    wstrb = 4'b0000;
    case (size)
      MEM_SZ_B: wstrb = 4'b0001 << lane;
      MEM_SZ_H: wstrb = 4'b0011 << lane;
      MEM_SZ_W: wstrb = 4'b1111;
      default:  wstrb = 4'b0000;
    endcase
  end

  // Bytes above the access size are shifted along too; the strobe masks them off.
  assign wword = wdata << {lane, 3'b000};
  assign rdata = rword >> {rlane, 3'b000};

endmodule

// File: rtl/ysyx_23060180_mem_resp.sv
// Word-organised RAM answering the core's single-port memory bus with 1-cycle read latency.
//   clk, rst_in            : clock, synchronous active-high reset
//   mem_rd, mem_wr         : read / write request this cycle
//   mem_raddr              : byte address (read and write)
//   mem_wdata, mem_wbit_en : right-justified store data, size code (1/2/4)
//   mem_rdata              : right-justified read data, valid the cycle after mem_rd
//   mem_err, mem_err_addr  : sticky error flag and address of the first erroring access
// Optional: define YSYX_23060180_MEM_PERF_EN to add perf_rd_cnt / perf_wr_cnt, counting
// accepted (non-erroring) reads and writes.
module ysyx_23060180_mem_resp
  import ysyx_23060180_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wbit_en,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] mem_err_addr
`ifdef YSYX_23060180_MEM_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt
`endif
);

  localparam logic [0:0]  StIdle = 1'b0;
  localparam logic [0:0]  StResp = 1'b1;
  localparam logic [31:0] Span   = 32'(4 * DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        rd_err, wr_err, wr_en;
  logic [3:0]  wstrb;
  logic [31:0] wword, rdata_al;

  logic [0:0]  state_q, state_d;
  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  assign off      = mem_raddr - BASE_ADDR;
  assign in_range = (mem_raddr >= BASE_ADDR) && (off < Span);
  assign idx      = off[AW+1:2];
  assign lane     = off[1:0];

  // Reads carry a size on mem_wbit_en too; only word reads care about alignment.
  assign rd_err = mem_rd && (!in_range || ((mem_wbit_en == MEM_SZ_W) && (lane != 2'd0)));
  assign wr_err = mem_wr && (!in_range || !lane_ok(mem_wbit_en, lane));
  assign wr_en  = mem_wr && !wr_err && !rst_in;

  ysyx_23060180_mem_align u_align (
    .wdata (mem_wdata),
    .size  (mem_wbit_en),
    .lane  (lane),
    .wstrb (wstrb),
    .wword (wword),
    .rword (word_q),
    .rlane (lane_q),
    .rdata (rdata_al)
  );

  // RAM array: no reset so it maps onto block RAM; the raw word register is read-first,
  // so a same-edge write to the same word is not visible in this response.
  always_ff @(posedge clk) begin
    if (mem_rd && in_range) begin
      word_q <= ram[idx];
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          ram[idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  // RESP means word_q/lane_q hold valid read data; IDLE forces zero (reset, out-of-range).
  always_comb begin
    state_d = state_q;
    if (mem_rd) begin
      state_d = in_range ? StResp : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= StIdle;
      lane_q     <= 2'd0;
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (mem_rd) begin
        lane_q <= lane;
      end
      if ((rd_err || wr_err) && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= mem_raddr;
      end
    end
  end

  assign mem_rdata    = (state_q == StResp) ? rdata_al : 32'd0;
  assign mem_err      = err_q;
  assign mem_err_addr = err_addr_q;

`ifdef YSYX_23060180_MEM_PERF_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      if (mem_rd && !rd_err) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (mem_wr && !wr_err) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign perf_rd_cnt = rd_cnt_q;
  assign perf_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060180_mem_resp.sv
module tb_ysyx_23060180_mem_resp;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_raddr, mem_wdata;
  logic [3:0]  mem_wbit_en;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] mem_err_addr;
`ifdef YSYX_23060180_MEM_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt;
`endif

  ysyx_23060180_mem_resp dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_raddr    (mem_raddr),
    .mem_wdata    (mem_wdata),
    .mem_wbit_en  (mem_wbit_en),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .mem_err_addr (mem_err_addr)
`ifdef YSYX_23060180_MEM_PERF_EN
    ,
    .perf_rd_cnt  (perf_rd_cnt),
    .perf_wr_cnt  (perf_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: a read accepted at a posedge is answered by the following negedge.
  logic        rd_pend  = 1'b0;
  logic        rst_pend = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_rdata = 32'd0;

  always @(posedge clk) begin
    rd_pend  <= mem_rd;
    rst_pend <= rst_in;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_pend) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", mem_rdata, e.rdata);
        check("err", {31'd0, mem_err}, {31'd0, e.err});
        check("err_addr", mem_err_addr, e.eaddr);
        last_rdata = e.rdata;
        have_last  = 1'b1;
      end
    end else if (rst_pend) begin
      last_rdata = 32'd0;
      have_last  = 1'b1;
      check("reset_rdata", mem_rdata, 32'd0);
    end else if (have_last) begin
      check("hold", mem_rdata, last_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sz);
    mem_wr = 1'b1; mem_raddr = a; mem_wdata = d; mem_wbit_en = sz;
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] sz,
                    input logic [31:0] er, input logic ee, input logic [31:0] ea);
    exp_t e;
    e.rdata = er; e.err = ee; e.eaddr = ea;
    sb.push_back(e);
    mem_rd = 1'b1; mem_raddr = a; mem_wbit_en = sz;
    step();
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input logic [31:0] ea);
    exp_t e;
    e.rdata = er; e.err = ee; e.eaddr = ea;
    sb.push_back(e);
    mem_rd = 1'b1; mem_wr = 1'b1; mem_raddr = a; mem_wdata = d; mem_wbit_en = 4'd4;
    step();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_raddr = 32'd0; mem_wdata = 32'd0; mem_wbit_en = 4'd0;

    // Reads issued during reset answer 0.
    rd(32'h8000_0000, 4'd4, 32'd0, 1'b0, 32'd0);
    rd(32'h8000_0000, 4'd4, 32'd0, 1'b0, 32'd0);
    rst_in = 1'b0;

    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'd4);
    rd(32'h8000_0000, 4'd4, 32'hDEAD_BEEF, 1'b0, 32'd0);

    // Byte merge into a word, then back-to-back reads.
    wr(32'h8000_0010, 32'h1122_3344, 4'd4);
    wr(32'h8000_0012, 32'h1234_56AA, 4'd1);
    rd(32'h8000_0010, 4'd4, 32'h11AA_3344, 1'b0, 32'd0);
    rd(32'h8000_0012, 4'd1, 32'h0000_11AA, 1'b0, 32'd0);
    step();

    // Half store, then misaligned half store is dropped and flagged.
    wr(32'h8000_0020, 32'h0000_0000, 4'd4);
    wr(32'h8000_0022, 32'hFFFF_BEEF, 4'd2);
    rd(32'h8000_0020, 4'd4, 32'hBEEF_0000, 1'b0, 32'd0);
    wr(32'h8000_0023, 32'h0000_1234, 4'd2);
    rd(32'h8000_0020, 4'd4, 32'hBEEF_0000, 1'b1, 32'h8000_0023);
    step();

    // Reset keeps RAM; range boundaries; first error address sticks.
    do_reset();
    step();
    rd(32'h8000_0010, 4'd4, 32'h11AA_3344, 1'b0, 32'd0);
    rd(32'h7FFF_FFFC, 4'd4, 32'd0, 1'b1, 32'h7FFF_FFFC);
    rd(32'h8000_4000, 4'd4, 32'd0, 1'b1, 32'h7FFF_FFFC);
    wr(32'h8000_3FFC, 32'h5A5A_5A5A, 4'd4);
    rd(32'h8000_3FFC, 4'd4, 32'h5A5A_5A5A, 1'b1, 32'h7FFF_FFFC);
    step();

    // Read-first on a simultaneous read and write.
    do_reset();
    wr(32'h8000_0004, 32'h0000_0001, 4'd4);
    rdwr(32'h8000_0004, 32'h0000_0002, 32'h0000_0001, 1'b0, 32'd0);
    rd(32'h8000_0004, 4'd4, 32'h0000_0002, 1'b0, 32'd0);

    // Illegal size code, then reset during a write clears the flag and blocks the write.
    wr(32'h8000_0008, 32'hFFFF_FFFF, 4'd3);
    rd(32'h8000_0000, 4'd4, 32'hDEAD_BEEF, 1'b1, 32'h8000_0008);
    begin
      exp_t e;
      e.rdata = 32'd0; e.err = 1'b0; e.eaddr = 32'd0;
      sb.push_back(e);
      rst_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1;
      mem_raddr = 32'h8000_0004; mem_wdata = 32'h0000_0099; mem_wbit_en = 4'd4;
      step();
      rst_in = 1'b0;
    end
`ifdef YSYX_23060180_MEM_PERF_EN
    check("perf_rd_reset", perf_rd_cnt, 32'd0);
    check("perf_wr_reset", perf_wr_cnt, 32'd0);
`endif
    rd(32'h8000_0004, 4'd4, 32'h0000_0002, 1'b0, 32'd0);
`ifdef YSYX_23060180_MEM_PERF_EN
    check("perf_rd_one", perf_rd_cnt, 32'd1);
    check("perf_wr_zero", perf_wr_cnt, 32'd0);
`endif
    // Misaligned word read: shifted data plus an error.
    rd(32'h8000_0011, 4'd4, 32'h0011_AA33, 1'b1, 32'h8000_0011);
`ifdef YSYX_23060180_MEM_PERF_EN
    check("perf_rd_err_skip", perf_rd_cnt, 32'd1);
    wr(32'h8000_0030, 32'h0000_0077, 4'd4);
    check("perf_wr_one", perf_wr_cnt, 32'd1);
`endif
    repeat (3) step();

    check("scoreboard_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060180_mem_resp.md
Name: ysyx_23060180_mem_resp

Overview:
Memory responder for the CPU core's single-port memory bus (mem_rd/mem_wr/mem_raddr/mem_rdata/mem_wdata/mem_wbit_en). It holds a word-organised RAM mapped at BASE_ADDR and answers reads with fixed 1-cycle latency, because the core samples mem_rdata exactly one cycle after mem_rd. It performs byte-lane alignment for sub-word stores and loads, and it flags out-of-range and misaligned accesses. It replaces the behavioural DPI memory in simulation and sits directly beside the core in the top-level.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address served.
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of two.
- AW, $clog2(DEPTH_WORDS), word-index width.

Ports:
- clk, input, 1, system clock.
- rst_in, input, 1, reset. Synchronous and active-high.
- mem_rd, input, 1, read request this cycle.
- mem_wr, input, 1, write request this cycle.
- mem_raddr, input, 32, byte address for both read and write.
- mem_wdata, input, 32, store data, right-justified (unshifted register value).
- mem_wbit_en, input, 4, store size code: 1 = byte, 2 = half, 4 = word, other values = no write.
- mem_rdata, output, 32, read data, right-justified, valid in the cycle after mem_rd.
- mem_err, output, 1, sticky access-error flag.
- mem_err_addr, output, 32, address of the first erroring access.

Behaviour:
- Reset (rst_in high at a posedge):
  - mem_rdata <= 0, mem_err <= 0, mem_err_addr <= 0.
  - No write commits in a reset cycle.
  - RAM contents are NOT cleared.
  - Any read issued in the reset cycle returns 0 on the following cycle.
- Decode:
  - off = mem_raddr - BASE_ADDR.
  - in_range = (mem_raddr >= BASE_ADDR) && (off < 4*DEPTH_WORDS).
  - idx = off[AW+1:2], lane = off[1:0].
- Read (mem_rd=1, in range):
  - At the next posedge, mem_rdata <= RAM[idx] >> (8*lane); vacated upper bits are 0.
  - The core performs sign/zero extension itself.
  - Latency is exactly 1 cycle. There is no ready/busy signal and no back-pressure.
- Read, out of range: mem_rdata <= 0 next cycle, and an error is raised.
- mem_rdata holds its last value while mem_rd=0.
- Write (mem_wr=1, in range, size legal and aligned):
  - Byte: byte lane "lane" <= mem_wdata[7:0].
  - Half: lane must be 0 or 2; lanes lane and lane+1 <= mem_wdata[15:0].
  - Word: lane must be 0; the whole word is written.
  - Unwritten lanes are preserved. The write commits at the posedge.
- Write errors (out of range, misaligned half or word, or size code not in {1,2,4}): the write is ignored and an error is raised.
- Misaligned word reads (lane != 0) return the shifted value and also raise an error.
- Error capture: mem_err is set at the posedge after the first error. mem_err_addr captures mem_raddr only when mem_err was 0; later errors do not overwrite it. Only reset clears the flag.
- Simultaneous mem_rd and mem_wr to the same word: read-first. mem_rdata returns pre-write data and the write commits in the same edge.
- State machine per request: IDLE → RESP. The RESP state drives the registered mem_rdata. Back-to-back reads on consecutive cycles are legal and each returns in order.

Optional Feature:
- Macro: YSYX_23060180_MEM_PERF_EN.
- Defined:
  - Adds output ports perf_rd_cnt[31:0] and perf_wr_cnt[31:0].
  - They count accepted (non-erroring) reads and writes, reset to 0 and wrap at 2^32.
  - A cycle with both mem_rd and mem_wr increments both counters.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ysyx_23060180_mem_pkg holds:
  - size codes MEM_SZ_B=4'd1, MEM_SZ_H=4'd2, MEM_SZ_W=4'd4;
  - MEM_BASE_DEFAULT=32'h8000_0000;
  - the function lane_ok(size, lane).
- One sub-module, ysyx_23060180_mem_align, is combinational:
  - store path: wdata plus size/lane → 4-bit byte strobe plus shifted write word;
  - load path: word plus lane → right-justified read data.

Test Plan:
- Reset, then mem_rd at 0x8000_0000 with RAM[0] preloaded to 0xDEADBEEF → mem_rdata=0xDEADBEEF exactly 1 cycle later; mem_err=0.
- Word write 0x11223344 at 0x8000_0010; byte write 0xAA (mem_wbit_en=1) at 0x8000_0012; read 0x8000_0010 → 0x11AA3344. Read 0x8000_0012 → 0x000011AA.
- Half write 0xBEEF at 0x8000_0022 over 0x00000000 → word reads 0xBEEF0000. Half write at 0x8000_0023 → ignored, mem_err=1, mem_err_addr=0x8000_0023.
- Read at 0x7FFF_FFFC → mem_rdata=0, mem_err=1. Then read at 0x8000_0000 + 4*DEPTH_WORDS → mem_err_addr still 0x7FFF_FFFC.
- Same cycle mem_rd+mem_wr to 0x8000_0004 (old 0x1, new 0x2) → mem_rdata=0x1 next cycle; a subsequent read returns 0x2.
- rst_in high during a write cycle → no commit (RAM unchanged), mem_rdata=0, mem_err cleared. With YSYX_23060180_MEM_PERF_EN defined, the counters read 0 after reset and increment by 1 per accepted access.
